// File: rtl/button_pkg.sv
// Shared state encoding and default timing for the button conditioner.
// Defaults assume a 50 MHz clock: 1 ms debounce, 0.5 s repeat delay, 0.1 s repeat period.
package button_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE,
    BTN_PRESS_WAIT,
    BTN_PRESSED,
    BTN_RELEASE_WAIT
  } btn_state_t;

  localparam int DEF_N_CH          = 3;
  localparam int DEF_STABLE_CYCLES = 50000;
  localparam int DEF_ACTIVE_LOW    = 1;
  localparam int DEF_REPEAT_DELAY  = 25000000;
  localparam int DEF_REPEAT_PERIOD = 5000000;

  // One spare bit so a counter sized for n can never wrap.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/button_chan.sv
// One debounced button channel: 2-flop synchronizer plus 4-state FSM; level and pulses registered,
// STABLE_CYCLES+2 cycles from raw edge to output. BUTTON_AUTOREPEAT_EN adds held-key repeat pulses.
module button_chan
  import button_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int ACTIVE_LOW    = DEF_ACTIVE_LOW
`ifdef BUTTON_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int            CW       = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic          RAW_IDLE = (ACTIVE_LOW != 0);

  logic [1:0]    sync;
  logic          s;
  btn_state_t    state;
  logic [CW-1:0] cnt;

  // Reset parks the synchronizer at the released level so a held key is seen as a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= {2{RAW_IDLE}};
    end else begin
      sync <= {sync[0], btn_raw};
    end
  end

  assign s = (ACTIVE_LOW != 0) ? ~sync[1] : sync[1];

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int            RW      = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                               : REPEAT_PERIOD);
  localparam logic [RW-1:0] RPT_DLY = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PER = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_first;
  logic [RW-1:0] rpt_last;

  assign rpt_last = rpt_first ? RPT_DLY : RPT_PER;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BTN_IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      rpt_cnt     <= '0;
      rpt_first   <= 1'b1;
`endif
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      case (state)
        BTN_IDLE: begin
          if (s) begin
            state <= BTN_PRESS_WAIT;
            cnt   <= CW'(1);
          end else begin
            cnt   <= '0;
          end
        end
        BTN_PRESS_WAIT: begin
          if (!s) begin
            state <= BTN_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= BTN_PRESSED;
            cnt       <= '0;
            btn_level <= 1'b1;
            btn_press <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BTN_PRESSED: begin
          if (!s) begin
            state <= BTN_RELEASE_WAIT;
            cnt   <= CW'(1);
          end
`ifdef BUTTON_AUTOREPEAT_EN
          else if (rpt_cnt == rpt_last) begin
            btn_press <= 1'b1;
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
          end else begin
            rpt_cnt <= rpt_cnt + RW'(1);
          end
`endif
        end
        BTN_RELEASE_WAIT: begin
          // A bounce back to pressed resumes the hold; the repeat timer stays frozen meanwhile.
          if (s) begin
            state <= BTN_PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= BTN_IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
            rpt_cnt     <= '0;
            rpt_first   <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= BTN_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// N_CH independent debounced buttons with level, press and release outputs, all registered;
// STABLE_CYCLES+2 cycles raw-to-output latency, no backpressure. BUTTON_AUTOREPEAT_EN enables auto-repeat.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_CH          = DEF_N_CH,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int ACTIVE_LOW    = DEF_ACTIVE_LOW,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release
);

  if (STABLE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("button_conditioner: STABLE_CYCLES must be >= 2 and repeat timings >= 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    button_chan #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
`ifdef BUTTON_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

endmodule
